clock_cache_mp: RTL and testbench

- Fully-associative K-way line cache with NUM_RD independent read ports, one write port with valid/ready handshake, and one invalidate port.
- Replacement is CLOCK with multi-bit reference counters. Invalid ways are filled first; hits update in place.
- Sits between requesters and a backing store; the backing store is outside this block.

---
 rtl/clock_cache_pkg.sv | 20 ++
 rtl/clock_cache_match.sv | 29 ++
 rtl/clock_cache_mp.sv | 216 +++++++++++++++++++++
 tb/tb_clock_cache_mp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_cache_pkg.sv
// Shared types and helpers for the CLOCK-replacement line cache.
package clock_cache_pkg;

  typedef enum logic {IDLE, SWEEP} write_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (vec[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

  function automatic int unsigned ref_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/clock_cache_match.sv
// Combinational tag compare across all ways: hit flag, one-hot and binary way index.
module clock_cache_match #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned K          = 4
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [K*ADDR_WIDTH-1:0] tags,
  input  logic [K-1:0]            valid,
  output logic                    hit,
  output logic [K-1:0]            onehot,
  output logic [$clog2(K)-1:0]    idx
);

  localparam int unsigned IDX_W = $clog2(K);

  // Tags are unique, so OR-ing matching indices yields the single match.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int unsigned w = 0; w < K; w++) begin
      if (valid[w] && tags[w*ADDR_WIDTH +: ADDR_WIDTH] == addr) begin
        onehot[w] = 1'b1;
        idx       = idx | IDX_W'(w);
      end
    end
    hit = |onehot;
  end

endmodule

// File: rtl/clock_cache_mp.sv
// Fully-associative multi-read-port line cache with CLOCK replacement and invalidate.
module clock_cache_mp
  import clock_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned K          = 4,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned REF_BITS   = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RD-1:0]            rd_valid,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_hit,
  output logic [NUM_RD*LINE_WIDTH-1:0] rd_data,
  input  logic                         wr_valid,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [LINE_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  output logic                         wr_done,
  output logic                         wr_was_hit,
  input  logic                         inv_valid,
  input  logic [ADDR_WIDTH-1:0]        inv_addr
);

  localparam int unsigned IDX_W = $clog2(K);
  localparam logic [REF_BITS-1:0] REF_MAX = REF_BITS'(ref_max(REF_BITS));

  logic [ADDR_WIDTH-1:0] tag_q  [K];
  logic [LINE_WIDTH-1:0] data_q [K];
  logic [REF_BITS-1:0]   ref_q  [K];
  logic [K-1:0]          valid_q;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  write_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q;
  logic [LINE_WIDTH-1:0] cap_data_q;

  logic [K*ADDR_WIDTH-1:0] tags_flat;

  always_comb begin
    tags_flat = '0;
    for (int unsigned w = 0; w < K; w++) begin
      tags_flat[w*ADDR_WIDTH +: ADDR_WIDTH] = tag_q[w];
    end
  end

  logic             r_hit    [NUM_RD];
  logic [K-1:0]     r_onehot [NUM_RD];
  logic [IDX_W-1:0] r_idx    [NUM_RD];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_match
    clock_cache_match #(.ADDR_WIDTH(ADDR_WIDTH), .K(K)) u_match (
      .addr   (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .tags   (tags_flat),
      .valid  (valid_q),
      .hit    (r_hit[p]),
      .onehot (r_onehot[p]),
      .idx    (r_idx[p])
    );
  end

  logic                  w_hit;
  logic [K-1:0]          w_onehot;
  logic [IDX_W-1:0]      w_idx;
  logic [ADDR_WIDTH-1:0] w_lookup;

  // While sweeping, the captured address is re-checked so a capture hit updates in place.
  assign w_lookup = (state_q == SWEEP) ? cap_addr_q : wr_addr;

  clock_cache_match #(.ADDR_WIDTH(ADDR_WIDTH), .K(K)) u_wr_match (
    .addr   (w_lookup),
    .tags   (tags_flat),
    .valid  (valid_q),
    .hit    (w_hit),
    .onehot (w_onehot),
    .idx    (w_idx)
  );

  logic             i_hit;
  logic [K-1:0]     i_onehot;
  logic [IDX_W-1:0] i_idx;

  clock_cache_match #(.ADDR_WIDTH(ADDR_WIDTH), .K(K)) u_inv_match (
    .addr   (inv_addr),
    .tags   (tags_flat),
    .valid  (valid_q),
    .hit    (i_hit),
    .onehot (i_onehot),
    .idx    (i_idx)
  );

  logic [31:0]     free_vec;
  logic [IDX_W-1:0] free_idx;
  logic             any_free;
  logic [K-1:0]     rd_ref_mask;

  always_comb begin
    free_vec          = '0;
    free_vec[K-1:0]   = ~valid_q;
    free_idx          = IDX_W'(lowest_set(free_vec));
    any_free          = ~&valid_q;
    rd_ref_mask       = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rd_valid[p]) rd_ref_mask = rd_ref_mask | r_onehot[p];
    end
  end

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_way;
  logic [ADDR_WIDTH-1:0] wr_tag;
  logic [LINE_WIDTH-1:0] wr_line;
  logic                  dec_en;
  logic                  capture;
  logic                  done_d;
  logic                  was_hit_d;

  assign wr_ready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en     = 1'b0;
    wr_way    = w_idx;
    wr_tag    = wr_addr;
    wr_line   = wr_data;
    dec_en    = 1'b0;
    capture   = 1'b0;
    done_d    = 1'b0;
    was_hit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          if (w_hit) begin
            wr_en     = 1'b1;
            done_d    = 1'b1;
            was_hit_d = 1'b1;
          end else if (any_free) begin
            wr_en  = 1'b1;
            wr_way = free_idx;
            done_d = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = SWEEP;
          end
        end
      end
      SWEEP: begin
        wr_tag  = cap_addr_q;
        wr_line = cap_data_q;
        if (w_hit) begin
          wr_en     = 1'b1;
          done_d    = 1'b1;
          was_hit_d = 1'b1;
          state_d   = IDLE;
        end else if (ref_q[ptr_q] == '0) begin
          wr_en   = 1'b1;
          wr_way  = ptr_q;
          done_d  = 1'b1;
          ptr_d   = ptr_q + 1'b1;
          state_d = IDLE;
        end else begin
          dec_en = 1'b1;
          ptr_d  = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      valid_q    <= '0;
      rd_hit     <= '0;
      rd_data    <= '0;
      wr_done    <= 1'b0;
      wr_was_hit <= 1'b0;
      for (int unsigned w = 0; w < K; w++) ref_q[w] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wr_done    <= done_d;
      wr_was_hit <= was_hit_d;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
        if (rd_valid[p] && r_hit[p]) begin
          rd_hit[p]                             <= 1'b1;
          rd_data[p*LINE_WIDTH +: LINE_WIDTH] <= data_q[r_idx[p]];
        end else begin
          rd_hit[p] <= 1'b0;
        end
      end
      // Later assignments win: sweep decrement beats a read hit on the way under ptr.
      for (int unsigned w = 0; w < K; w++) begin
        if (rd_ref_mask[w]) ref_q[w] <= REF_MAX;
      end
      if (dec_en) ref_q[ptr_q] <= ref_q[ptr_q] - 1'b1;
      if (wr_en)  ref_q[wr_way] <= REF_MAX;
      if (inv_valid && i_hit) valid_q[i_idx] <= 1'b0;
      if (wr_en) valid_q[wr_way] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      tag_q[wr_way]  <= wr_tag;
      data_q[wr_way] <= wr_line;
    end
    if (!reset && capture) begin
      cap_addr_q <= wr_addr;
      cap_data_q <= wr_data;
    end
  end

endmodule

// File: tb/tb_clock_cache_mp.sv
// Directed bench for clock_cache_mp: read results flow through a scoreboard queue.
module tb_clock_cache_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  rd_valid;
  logic [15:0] rd_addr;
  logic [1:0]  rd_hit;
  logic [63:0] rd_data;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        wr_done;
  logic        wr_was_hit;
  logic        inv_valid;
  logic [7:0]  inv_addr;

  clock_cache_mp #(
    .ADDR_WIDTH(8), .LINE_WIDTH(32), .K(4), .NUM_RD(2), .REF_BITS(2)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_done(wr_done), .wr_was_hit(wr_was_hit),
    .inv_valid(inv_valid), .inv_addr(inv_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int unsigned port;
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_data [2];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned low_cnt;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    last_data[0] = '0;
    last_data[1] = '0;
  endtask

  // Misses and idle ports keep the previously returned data.
  task automatic push_exp(input string tag, input int unsigned port, input logic v,
                          input logic h, input logic [31:0] d);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.hit  = v & h;
    e.data = (v && h) ? d : last_data[port];
    last_data[port] = e.data;
    sb.push_back(e);
  endtask

  task automatic rd(input string tag,
                    input logic v0, input logic [7:0] a0, input logic h0, input logic [31:0] d0,
                    input logic v1, input logic [7:0] a1, input logic h1, input logic [31:0] d1);
    exp_t e;
    rd_valid = {v1, v0};
    rd_addr  = {a1, a0};
    push_exp({tag, "_p0"}, 0, v0, h0, d0);
    push_exp({tag, "_p1"}, 1, v1, h1, d1);
    tick();
    rd_valid = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_hit"}, 64'(rd_hit[e.port]), 64'(e.hit));
      chk({e.tag, "_data"}, 64'(rd_data[e.port*32 +: 32]), 64'(e.data));
    end
  endtask

  // Issue one write and wait (bounded) for wr_done; low_cnt counts wr_ready-low cycles.
  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                    input logic exp_hit, input int unsigned exp_low);
    int unsigned cycles;
    chk({tag, "_ready"}, 64'(wr_ready), 64'(1));
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_addr  = 8'hEE;
    wr_data  = 32'hDEADBEEF;
    cycles   = 0;
    low_cnt  = 0;
    while (!wr_done && cycles < 100) begin
      if (!wr_ready) low_cnt++;
      tick();
      cycles++;
    end
    chk({tag, "_done"}, 64'(wr_done), 64'(1));
    chk({tag, "_was_hit"}, 64'(wr_was_hit), 64'(exp_hit));
    chk({tag, "_ready_low"}, 64'(low_cnt), 64'(exp_low));
  endtask

  initial begin
    int unsigned seen_done;
    reset     = 1'b1;
    rd_valid  = '0;
    rd_addr   = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    inv_valid = 1'b0;
    inv_addr  = '0;
    do_reset();

    chk("reset_rd_hit", 64'(rd_hit), 64'(0));
    chk("reset_rd_data", rd_data, 64'(0));
    chk("reset_wr_done", 64'(wr_done), 64'(0));
    chk("reset_wr_ready", 64'(wr_ready), 64'(1));

    rd("empty", 1, 8'h10, 0, 0, 1, 8'h10, 0, 0);

    wr("wr10", 8'h10, 32'hAAAA0001, 0, 0);
    rd("rd10", 0, 8'h00, 0, 0, 1, 8'h10, 1, 32'hAAAA0001);
    chk("wr_done_pulse", 64'(wr_done), 64'(0));

    do_reset();
    for (int unsigned i = 1; i <= 4; i++) begin
      wr($sformatf("fill%0d", i), 8'(i), 32'h100 + i, 0, 0);
    end
    wr("rewrite02", 8'h02, 32'h55, 1, 0);
    rd("rd02", 1, 8'h02, 1, 32'h55, 1, 8'h04, 1, 32'h104);

    // All refs at 3, ptr at 0: three full decrement rounds, then way 0 is evicted.
    wr("evict", 8'h09, 32'h99, 0, 13);
    rd("post_evict", 1, 8'h01, 0, 0, 1, 8'h09, 1, 32'h99);
    rd("survivors", 1, 8'h02, 1, 32'h55, 1, 8'h03, 1, 32'h103);

    inv_valid = 1'b1;
    inv_addr  = 8'h03;
    rd("inv_same_cycle", 1, 8'h03, 1, 32'h103, 0, 0, 0, 0);
    inv_valid = 1'b0;
    rd("inv_after", 1, 8'h03, 0, 0, 1, 8'h04, 1, 32'h104);
    wr("refill", 8'h0A, 32'hA0A0, 0, 0);
    rd("refill_rd", 1, 8'h0A, 1, 32'hA0A0, 1, 8'h09, 1, 32'h99);
    rd("no_evict", 1, 8'h02, 1, 32'h55, 1, 8'h04, 1, 32'h104);

    inv_valid = 1'b1;
    inv_addr  = 8'h04;
    wr_valid  = 1'b1;
    wr_addr   = 8'h04;
    wr_data   = 32'h4444;
    tick();
    wr_valid  = 1'b0;
    inv_valid = 1'b0;
    chk("wr_beats_inv_done", 64'(wr_done), 64'(1));
    chk("wr_beats_inv_hit", 64'(wr_was_hit), 64'(1));
    rd("wr_beats_inv_rd", 1, 8'h04, 1, 32'h4444, 0, 0, 0, 0);

    wr_valid = 1'b1;
    wr_addr  = 8'h0B;
    wr_data  = 32'hBBBB;
    tick();
    wr_valid = 1'b0;
    chk("sweep_entered", 64'(wr_ready), 64'(0));
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_data[0] = '0;
    last_data[1] = '0;
    chk("rst_sweep_done", 64'(wr_done), 64'(0));
    chk("rst_sweep_ready", 64'(wr_ready), 64'(1));
    seen_done = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      tick();
      if (wr_done) seen_done++;
    end
    chk("rst_sweep_no_done", 64'(seen_done), 64'(0));
    rd("rst_rd_a", 1, 8'h0B, 0, 0, 1, 8'h09, 0, 0);
    rd("rst_rd_b", 1, 8'h02, 0, 0, 1, 8'h04, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
